// File: rtl/warp_pkg.sv
// rtl/warp_pkg.sv - shared types and defaults for the warp state table
// Purpose: per-slot state encoding and the default PC increment.
// Ports: none (package).
package warp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACTIVE = 2'b01,
      DONE   = 2'b10
   } warp_state_e;

   localparam int PC_STEP_DEFAULT = 2;

endpackage

// File: rtl/warp_slot.sv
// rtl/warp_slot.sv - state, PC and readiness for one warp slot
// Purpose: IDLE/ACTIVE/DONE state machine with PC and registered readiness
//          for a single warp. Per-slot priority: launch (only when not
//          ACTIVE) > exit > branch > issue.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   launch, launch_pc launch request addressed to this slot, start PC
//   future_ready      readiness of this warp from the readiness check
//   issue             issue addressed to this slot
//   exit_hit          EXIT addressed to this slot
//   br, br_target     taken branch addressed to this slot, target PC
//   state, pc, ready  registered slot state, PC and readiness
//   issue_bad         combinational: addressed issue is invalid and not
//                     superseded by a higher-priority event
module warp_slot
   import warp_pkg::*;
#(
   parameter int PC_WIDTH = 8,
   parameter int PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                launch,
   input  logic [PC_WIDTH-1:0] launch_pc,
   input  logic                future_ready,
   input  logic                issue,
   input  logic                exit_hit,
   input  logic                br,
   input  logic [PC_WIDTH-1:0] br_target,
   output warp_state_e         state,
   output logic [PC_WIDTH-1:0] pc,
   output logic                ready,
   output logic                issue_bad
);

   warp_state_e         state_next;
   logic [PC_WIDTH-1:0] pc_next;
   logic                ready_next;
   logic                is_active;
   logic                issue_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         ready <= ready_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      ready_next = 1'b0;
      issue_bad  = 1'b0;
      is_active  = (state == ACTIVE);
      issue_ok   = issue && is_active && ready;

      if (launch && !is_active) begin
         state_next = ACTIVE;
         pc_next    = launch_pc;
      end else if (exit_hit && is_active) begin
         state_next = DONE;
      end else if (br && is_active) begin
         // Redirect flushes readiness for one cycle.
         pc_next = br_target;
      end else if (issue_ok) begin
         // Natural truncation gives wrap modulo 2^PC_WIDTH.
         pc_next = pc + PC_WIDTH'(PC_STEP);
      end else begin
         ready_next = future_ready && is_active;
      end

      // An issue dropped in favour of exit/branch is not an error.
      if (issue && !issue_ok && !(is_active && (exit_hit || br))) begin
         issue_bad = 1'b1;
      end
   end

endmodule

// File: rtl/warp_state_table.sv
// rtl/warp_state_table.sv - per-warp state/PC/readiness table for a warp scheduler
// Purpose: holds NUM_WARPS warp slots, routes launch/issue/exit/branch events
//          to them and reports PCs, readiness, activity and completion.
// Config:  WARP_BRANCH_EN adds the br_valid/br_id/br_target redirect port.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   launch_valid/id/pc         start a warp; launch_ready (comb) when slot not ACTIVE
//   future_ready               per-warp readiness input
//   issue_valid/id             scheduler issued a warp
//   exit_valid/id              warp executed EXIT
//   br_valid/id/target         taken-branch redirect (WARP_BRANCH_EN only)
//   pc_out                     packed per-warp PCs, warp i at [i*PC_WIDTH +: PC_WIDTH]
//   ready_out, active_out      per-warp registered readiness, ACTIVE flags
//   all_done                   no warp ACTIVE and at least one DONE
//   issue_err                  one-cycle pulse after an invalid issue
module warp_state_table
   import warp_pkg::*;
#(
   parameter int NUM_WARPS = 4,
   parameter int PC_WIDTH  = 8,
   parameter int PC_STEP   = PC_STEP_DEFAULT,
   localparam int WID      = $clog2(NUM_WARPS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          launch_valid,
   input  logic [WID-1:0]                launch_id,
   input  logic [PC_WIDTH-1:0]           launch_pc,
   output logic                          launch_ready,
   input  logic [NUM_WARPS-1:0]          future_ready,
   input  logic                          issue_valid,
   input  logic [WID-1:0]                issue_id,
   input  logic                          exit_valid,
   input  logic [WID-1:0]                exit_id,
`ifdef WARP_BRANCH_EN
   input  logic                          br_valid,
   input  logic [WID-1:0]                br_id,
   input  logic [PC_WIDTH-1:0]           br_target,
`endif
   output logic [NUM_WARPS*PC_WIDTH-1:0] pc_out,
   output logic [NUM_WARPS-1:0]          ready_out,
   output logic [NUM_WARPS-1:0]          active_out,
   output logic                          all_done,
   output logic                          issue_err
);

   logic                br_v;
   logic [WID-1:0]      br_i;
   logic [PC_WIDTH-1:0] br_t;

`ifdef WARP_BRANCH_EN
   assign br_v = br_valid;
   assign br_i = br_id;
   assign br_t = br_target;
`else
   assign br_v = 1'b0;
   assign br_i = '0;
   assign br_t = '0;
`endif

   warp_state_e          slot_state [NUM_WARPS];
   logic [NUM_WARPS-1:0] slot_bad;
   logic [NUM_WARPS-1:0] done_vec;

   for (genvar i = 0; i < NUM_WARPS; i++) begin : g_slot
      warp_slot #(
         .PC_WIDTH (PC_WIDTH),
         .PC_STEP  (PC_STEP)
      ) u_slot (
         .clk          (clk),
         .reset        (reset),
         .launch       (launch_valid && (launch_id == WID'(i))),
         .launch_pc    (launch_pc),
         .future_ready (future_ready[i]),
         .issue        (issue_valid && (issue_id == WID'(i))),
         .exit_hit     (exit_valid && (exit_id == WID'(i))),
         .br           (br_v && (br_i == WID'(i))),
         .br_target    (br_t),
         .state        (slot_state[i]),
         .pc           (pc_out[i*PC_WIDTH +: PC_WIDTH]),
         .ready        (ready_out[i]),
         .issue_bad    (slot_bad[i])
      );

      assign active_out[i] = (slot_state[i] == ACTIVE);
      assign done_vec[i]   = (slot_state[i] == DONE);
   end

   assign launch_ready = (slot_state[launch_id] != ACTIVE);
   assign all_done     = !(|active_out) && (|done_vec);

   // Only the issued slot can flag, so OR-reduction is the addressed slot's result.
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_err <= 1'b0;
      end else begin
         issue_err <= |slot_bad;
      end
   end

endmodule

// File: doc/warp_state_table.md
WARP_STATE_TABLE -- requirements
Module: warp_state_table

Interface
REQ-001 Parameter NUM_WARPS, default 4, number of warp slots (power of two, at least 2).
REQ-002 Parameter PC_WIDTH, default 8, program counter width.
REQ-003 Parameter PC_STEP, default 2, PC increment per issued instruction.
REQ-004 Parameter WID, default clog2(NUM_WARPS), warp-id width, derived and not overridden.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 launch_valid  input  1  request to start a warp.
REQ-008 launch_id  input  WID  target warp slot.
REQ-009 launch_pc  input  PC_WIDTH  start PC of the launched warp.
REQ-010 launch_ready  output  1  combinational; high when slot launch_id is not ACTIVE.
REQ-011 future_ready  input  NUM_WARPS  per-warp readiness from the readiness check.
REQ-012 issue_valid  input  1  scheduler issued a warp this cycle.
REQ-013 issue_id  input  WID  issued warp.
REQ-014 exit_valid  input  1  a warp executed EXIT.
REQ-015 exit_id  input  WID  exiting warp.
REQ-016 br_valid, br_id, br_target  input  1, WID, PC_WIDTH  taken-branch redirect (WARP_BRANCH_EN only).
REQ-017 pc_out  output  NUM_WARPS*PC_WIDTH  per-warp PCs; warp i occupies bits [i*PC_WIDTH +: PC_WIDTH].
REQ-018 ready_out  output  NUM_WARPS  registered per-warp readiness.
REQ-019 active_out  output  NUM_WARPS  per-warp ACTIVE flag.
REQ-020 all_done  output  1  no warp ACTIVE and at least one warp DONE.
REQ-021 issue_err  output  1  one-cycle pulse when an issue targets a non-ready or non-ACTIVE warp.

Function
REQ-022 Each slot SHALL hold a state machine with states IDLE, ACTIVE and DONE, plus a PC register and a ready register.
REQ-023 Launch accepted when launch_valid && launch_ready: next cycle state=ACTIVE, pc=launch_pc, ready=0.
REQ-024 A launch targeting an ACTIVE slot SHALL be ignored, with no state change.
REQ-025 Valid issue (slot ACTIVE and ready_out=1): pc <= pc+PC_STEP, truncated to PC_WIDTH so it wraps modulo 2^PC_WIDTH; ready <= 0 next cycle regardless of future_ready.
REQ-026 Invalid issue: no PC or state change; issue_err=1 on the next cycle only.
REQ-027 Otherwise, ready[i] <= future_ready[i] && state[i]==ACTIVE, giving one-cycle latency.
REQ-028 Exit on an ACTIVE slot: state <= DONE, ready <= 0, PC held; exit on a non-ACTIVE slot is ignored.
REQ-029 Branch on an ACTIVE slot: pc <= br_target, ready <= 0 for one cycle (flush).
REQ-030 Per-slot priority on the same cycle is exit > branch > issue; a lower-priority event on the same slot is dropped, without raising issue_err.
REQ-031 Events on different slots in the same cycle SHALL apply independently.
REQ-032 DONE and IDLE slots SHALL accept relaunch; a DONE slot relaunches to ACTIVE.
REQ-033 all_done and active_out SHALL be combinational from the state registers.

Reset
REQ-034 On reset high at a clock edge, all slots SHALL go to IDLE, pc=0, ready_out=0 and issue_err=0.
REQ-035 Reset SHALL override any concurrent launch, issue, exit or branch.
REQ-036 After reset: all_done=0, active_out=0, and launch_ready=1.

Configuration
REQ-037 Macro WARP_BRANCH_EN defined: br_* ports are present and REQ-029/REQ-030 apply.
REQ-038 WARP_BRANCH_EN undefined: br_* ports are absent, and priority is exit > issue.

Structure
REQ-039 Shared package warp_pkg SHALL hold the state encoding (IDLE=2'b00, ACTIVE=2'b01, DONE=2'b10) and the PC_STEP default.
REQ-040 One sub-module, warp_slot (state, PC, ready for one warp), SHALL be instantiated NUM_WARPS times by a generate loop.

Verification
REQ-041 Reset, launch warp 1 at pc 0x10, future_ready[1]=1 -> active_out=0010; ready_out[1]=1 one cycle after the launch registers.
REQ-042 Issue warp 1 twice with ready re-asserted between issues -> pc 0x12 then 0x14; ready_out[1]=0 the cycle after each issue.
REQ-043 Warp 0 launched at pc 0xFE, issued -> pc wraps to 0x00.
REQ-044 Same cycle: exit and issue on warp 2 -> state DONE, PC unchanged, issue_err=0; issue to IDLE warp 3 -> issue_err pulses one cycle.
REQ-045 WARP_BRANCH_EN, same cycle: branch warp 1 to 0x40 and issue warp 1 -> pc=0x40, ready_out[1]=0 one cycle.
REQ-046 Launch warps 0 to 3, exit all -> all_done=1; relaunch warp 0 -> all_done=0; reset mid-run -> all outputs at reset values the next cycle.
